alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 41 ++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct3 opcode encoding and shift-amount width.
// Imported by alu_core, alu_arbiter and the bench.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  localparam int SHAMT_W = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational RV32-style ALU for the granted request.
// Ports: op_i (funct3), func7_i (sub/sra), ra_i, rb_i operands, res_o result.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic            func7_i,
  input  logic [XLEN-1:0] ra_i,
  input  logic [XLEN-1:0] rb_i,
  output logic [XLEN-1:0] res_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;

  assign shamt = rb_i[SHAMT_W-1:0];
  assign lt_s  = $signed(ra_i) < $signed(rb_i);
  assign lt_u  = ra_i < rb_i;

  always_comb begin
    res_o = '0;
    unique case (alu_op_e'(op_i))
      ALU_ADD:  res_o = func7_i ? ra_i - rb_i
                                : ra_i + rb_i;
      ALU_SLL:  res_o = ra_i << shamt;
      ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  res_o = ra_i ^ rb_i;
      ALU_SR:   res_o = func7_i
                        ? $unsigned($signed(ra_i) >>> shamt)
                        : ra_i >> shamt;
      ALU_OR:   res_o = ra_i | rb_i;
      ALU_AND:  res_o = ra_i & rb_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a single-entry result register.
// Ports: clk, rst_n (async low); req0_*/req1_* valid/ready/op/func7/ra/rb/tag;
// rsp_valid/rsp_ready/rsp_out/rsp_src/rsp_tag result side.
// Macro ALU_ARB_RR_EN: round-robin on ties; otherwise req0 always wins.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic             req0_func7,
  input  logic [XLEN-1:0]  req0_ra,
  input  logic [XLEN-1:0]  req0_rb,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic             req1_func7,
  input  logic [XLEN-1:0]  req1_ra,
  input  logic [XLEN-1:0]  req1_rb,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_out,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  out_q, out_d;
  logic             src_q, src_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             slot_free;
  logic             sel1;
  logic             gnt0, gnt1;
  logic             accept;

  logic [2:0]       g_op;
  logic             g_f7;
  logic [XLEN-1:0]  g_ra, g_rb;
  logic [TAG_W-1:0] g_tag;
  logic [XLEN-1:0]  alu_res;

  assign slot_free = !valid_q || rsp_ready;

`ifdef ALU_ARB_RR_EN
  logic ptr_q, ptr_d;

  // ptr names the requester favoured on a tie
  assign sel1 = (req0_valid && req1_valid) ? ptr_q
                                           : req1_valid;
`else
  assign sel1 = req1_valid && !req0_valid;
`endif

  assign gnt0 = req0_valid && !sel1;
  assign gnt1 = req1_valid && sel1;

  // rst_n gate keeps both readies low during reset
  assign req0_ready = gnt0 && slot_free && rst_n;
  assign req1_ready = gnt1 && slot_free && rst_n;
  assign accept     = req0_ready || req1_ready;

  assign g_op  = sel1 ? req1_op    : req0_op;
  assign g_f7  = sel1 ? req1_func7 : req0_func7;
  assign g_ra  = sel1 ? req1_ra    : req0_ra;
  assign g_rb  = sel1 ? req1_rb    : req0_rb;
  assign g_tag = sel1 ? req1_tag   : req0_tag;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu (
    .op_i    (g_op),
    .func7_i (g_f7),
    .ra_i    (g_ra),
    .rb_i    (g_rb),
    .res_o   (alu_res)
  );

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    src_d   = src_q;
    tag_d   = tag_q;
    if (accept) begin
      valid_d = 1'b1;
      out_d   = alu_res;
      src_d   = sel1;
      tag_d   = g_tag;
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      src_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = !sel1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign rsp_valid = valid_q;
  assign rsp_out   = out_q;
  assign rsp_src   = src_q;
  assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors, queued expectations.
// Honours ALU_ARB_RR_EN for the tie-break expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_op;
  logic             req0_func7;
  logic [XLEN-1:0]  req0_ra, req0_rb;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_op;
  logic             req1_func7;
  logic [XLEN-1:0]  req1_ra, req1_rb;
  logic [TAG_W-1:0] req1_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_out;
  logic             rsp_src;
  logic [TAG_W-1:0] rsp_tag;

  typedef struct packed {
    logic [XLEN-1:0]  out;
    logic             src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_arbiter #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_func7 (req0_func7),
    .req0_ra    (req0_ra),
    .req0_rb    (req0_rb),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_func7 (req1_func7),
    .req1_ra    (req1_ra),
    .req1_rb    (req1_rb),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result fires at the next edge when valid && ready now
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %h src %0d tag %h expected none",
                 rsp_out, rsp_src, rsp_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_out", rsp_out, e.out);
        chk("rsp_src", {31'd0, rsp_src}, {31'd0, e.src});
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
      end
    end
  end

  task automatic set_req(input int n, input logic [2:0] op,
                         input logic f7, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] tag);
    if (n == 0) begin
      req0_op = op; req0_func7 = f7;
      req0_ra = a;  req0_rb = b; req0_tag = tag;
    end else begin
      req1_op = op; req1_func7 = f7;
      req1_ra = a;  req1_rb = b; req1_tag = tag;
    end
  endtask

  // Entered and left at posedge+1; request is accepted this cycle
  task automatic issue(input int n, input logic [2:0] op,
                       input logic f7, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] exp, input bit push);
    set_req(n, op, f7, a, b, tag);
    req0_valid = (n == 0);
    req1_valid = (n == 1);
    if (push) exp_q.push_back({exp, n[0], tag});
    @(negedge clk);
    chk($sformatf("ready%0d_issue", n),
        {31'd0, (n == 0) ? req0_ready : req1_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  bit g_seq[4];

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set_req(0, ALU_ADD, 1'b0, '0, '0, '0);
    set_req(1, ALU_ADD, 1'b0, '0, '0, '0);

    // Reset state; ready must stay low even with a valid request
    req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with one-cycle latency
    issue(0, ALU_ADD, 1'b0, 32'd5, 32'd7, 4'd3, 32'd12, 1'b1);
    @(negedge clk);
    chk("add_latency_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back operand corner cases
    issue(0, ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'd1, 32'd0, 1'b1);
    issue(1, ALU_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd1, 1'b1);
    issue(0, ALU_SR,   1'b1, 32'h8000_0000, 32'd33, 4'd4,
          32'hC000_0000, 1'b1);
    issue(1, ALU_ADD,  1'b1, 32'd0, 32'd1, 4'd5, 32'hFFFF_FFFF, 1'b1);
    issue(0, ALU_SLL,  1'b0, 32'd1, 32'd31, 4'd6, 32'h8000_0000, 1'b1);
    issue(1, ALU_SR,   1'b0, 32'h8000_0000, 32'd4, 4'd7,
          32'h0800_0000, 1'b1);
    issue(0, ALU_AND,  1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 4'd8,
          32'h0000_00F0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held, both readies low, then release
    rsp_ready = 1'b0;
    issue(0, ALU_OR, 1'b0, 32'h0000_F000, 32'h0000_000F, 4'd1,
          32'h0000_F00F, 1'b1);
    set_req(0, ALU_XOR, 1'b0, 32'h0000_00FF, 32'h0000_000F, 4'd2);
    set_req(1, ALU_ADD, 1'b0, 32'd1, 32'd1, 4'd9);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
      chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_out", rsp_out, 32'h0000_F00F);
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    exp_q.push_back({32'h0000_00F0, 1'b0, 4'd2});
    @(negedge clk);
    chk("release_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("release_keep_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset while a result is held; last accept was req0
    rsp_ready = 1'b0;
    issue(0, ALU_ADD, 1'b0, 32'd1, 32'd1, 4'd9, 32'd2, 1'b0);
    @(negedge clk);
    chk("pre_reset_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_out", rsp_out, 32'd0);
    chk("async_rst_ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie test straight after reset: first tie goes to req0
`ifdef ALU_ARB_RR_EN
    g_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    g_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    set_req(0, ALU_ADD, 1'b0, 32'd100, 32'd1, 4'hA);
    set_req(1, ALU_XOR, 1'b0, 32'h0000_00FF, 32'h0000_000F, 4'h5);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (g_seq[i]) exp_q.push_back({32'h0000_00F0, 1'b1, 4'h5});
      else          exp_q.push_back({32'd101, 1'b0, 4'hA});
      @(negedge clk);
      chk($sformatf("tie%0d_ready0", i), {31'd0, req0_ready},
          {31'd0, !g_seq[i]});
      chk($sformatf("tie%0d_ready1", i), {31'd0, req1_ready},
          {31'd0, g_seq[i]});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
